// File: rtl/pe_mac_seq.sv
// Floating-point multiply-accumulate PE: sums KERNEL_LEN products, adds bias, optional ReLU.
// Latency: result valid 3 cycles after the last pair is accepted (DRAIN, BIAS, then OUT).
// Backpressure: in_ready low outside ACC; the result is held in OUT until out_ready.
//
// Ports: clk/reset (sync, active-high), clear (sync abort of the current result),
//        in_valid/in_ready + floatA/floatB (operand pairs), bias/relu_en (sampled in BIAS),
//        out_valid/out_ready + result (registered finished sum).
// Arithmetic: round-to-nearest-even, denormals flushed to zero, overflow saturates to
// infinity; Inf/NaN operands are not special-cased.
module pe_mac_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int KERNEL_LEN = 9,
    parameter int USE_BIAS   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] floatA,
    input  logic [DATA_WIDTH-1:0] floatB,
    input  logic [DATA_WIDTH-1:0] bias,
    input  logic                  relu_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int DW    = DATA_WIDTH;
    localparam int EW    = (DW == 32) ? 8 : 5;
    localparam int MW    = DW - 1 - EW;
    localparam int CW    = $clog2(KERNEL_LEN + 1);

    // Two spare bits keep exponent intermediates (product sums, normalisation underflow) in range.
    typedef logic signed [EW+1:0] exp_t;
    localparam exp_t EXP_BIAS = exp_t'((1 << (EW - 1)) - 1);
    localparam exp_t EXP_MAX  = exp_t'((1 << EW) - 1);
    localparam exp_t EXP_ONE  = exp_t'(1);
    localparam exp_t EXP_ZERO = exp_t'(0);
    localparam exp_t SHIFT_LIM = exp_t'(MW + 3);
    localparam logic [CW-1:0] KLEN  = CW'(KERNEL_LEN);
    localparam logic [CW-1:0] KLAST = CW'(KERNEL_LEN - 1);

    typedef enum logic [1:0] {ACC, DRAIN, BIAS, OUT} state_t;

    // Round a normalised mantissa (hidden bit stripped) and pack, flushing underflow to zero.
    function automatic logic [DW-1:0] round_pack(input logic s, input exp_t e_in,
                                                 input logic [MW-1:0] f_in,
                                                 input logic g, input logic st);
        logic [MW:0] fr;
        exp_t        e;
        e  = e_in;
        fr = {1'b0, f_in} + {{MW{1'b0}}, (g & (st | f_in[0]))};
        if (fr[MW]) e = e + EXP_ONE;     // 1.11..1 rounded up to 10.0
        if (e <= EXP_ZERO) return {s, {(DW-1){1'b0}}};
        if (e >= EXP_MAX)  return {s, {EW{1'b1}}, {MW{1'b0}}};
        return {s, e[EW-1:0], fr[MW-1:0]};
    endfunction

    function automatic logic [DW-1:0] fmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic             s;
        logic [2*MW+1:0]  ma, mb, p;
        exp_t             e;
        s = a[DW-1] ^ b[DW-1];
        if (a[DW-2:MW] == '0 || b[DW-2:MW] == '0) return {s, {(DW-1){1'b0}}};
        ma = {{(MW+1){1'b0}}, 1'b1, a[MW-1:0]};
        mb = {{(MW+1){1'b0}}, 1'b1, b[MW-1:0]};
        p  = ma * mb;
        e  = exp_t'({2'b00, a[DW-2:MW]}) + exp_t'({2'b00, b[DW-2:MW]}) - EXP_BIAS;
        if (p[2*MW+1]) return round_pack(s, e + EXP_ONE, p[2*MW:MW+1], p[MW], |p[MW-1:0]);
        return round_pack(s, e, p[2*MW-1:MW], p[MW-1], |p[MW-2:0]);
    endfunction

    function automatic logic [DW-1:0] fadd(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] x, y;
        logic [MW+3:0] mx, my, ms;      // hidden bit, fraction, guard/round/sticky
        logic [MW+4:0] sum;
        exp_t          e, d;
        logic          a_z, b_z;
        a_z = (a[DW-2:MW] == '0);
        b_z = (b[DW-2:MW] == '0);
        if (a_z && b_z) return {a[DW-1] & b[DW-1], {(DW-1){1'b0}}};
        if (a_z) return b;
        if (b_z) return a;
        // x carries the larger magnitude, so the subtraction below cannot go negative.
        if (a[DW-2:0] >= b[DW-2:0]) begin x = a; y = b; end
        else                        begin x = b; y = a; end
        e  = exp_t'({2'b00, x[DW-2:MW]});
        d  = e - exp_t'({2'b00, y[DW-2:MW]});
        mx = {1'b1, x[MW-1:0], 3'b000};
        my = {1'b1, y[MW-1:0], 3'b000};
        if (d > SHIFT_LIM) begin
            ms = {{(MW+3){1'b0}}, 1'b1};
        end else begin
            ms = my >> d;
            if ((ms << d) != my) ms[0] = 1'b1;
        end
        if (x[DW-1] == y[DW-1]) sum = {1'b0, mx} + {1'b0, ms};
        else                    sum = {1'b0, mx} - {1'b0, ms};
        if (sum == '0) return '0;
        if (sum[MW+4]) begin
            sum = {1'b0, sum[MW+4:2], sum[1] | sum[0]};
            e   = e + EXP_ONE;
        end
        for (int i = 0; i < MW + 3; i++) begin
            if (!sum[MW+3]) begin
                sum = sum << 1;
                e   = e - EXP_ONE;
            end
        end
        return round_pack(x[DW-1], e, sum[MW+2:3], sum[2], |sum[1:0]);
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   prod_q, prod_d, acc_q, acc_d, result_q, result_d, bias_sum;
    logic            prod_v_q, prod_v_d, accept;

    assign in_ready  = (state_q == ACC) && (cnt_q < KLEN) && !clear;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == OUT);
    assign result    = result_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (accept && cnt_q == KLAST) state_d = DRAIN;
            DRAIN:   state_d = BIAS;
            BIAS:    state_d = OUT;
            OUT:     if (out_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
        if (clear) state_d = ACC;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ACC;
        else       state_q <= state_d;
    end

    always_comb begin
        bias_sum = (USE_BIAS != 0) ? fadd(acc_q, bias) : acc_q;
        prod_d   = prod_q;
        prod_v_d = accept;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (accept) begin
            prod_d = fmul(floatA, floatB);
            cnt_d  = cnt_q + CW'(1);
        end
        if (prod_v_q) acc_d = fadd(acc_q, prod_q);
        // Sign-bit test also maps -0 to +0 under ReLU.
        if (state_q == BIAS && !clear) result_d = (relu_en && bias_sum[DW-1]) ? '0 : bias_sum;
        if ((state_q == OUT && out_ready) || clear) begin
            acc_d    = '0;
            cnt_d    = '0;
            prod_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            prod_v_q <= prod_v_d;
            result_q <= result_d;
        end
    end
endmodule

// File: doc/pe_mac_seq.md
PE_MAC_SEQ -- requirements
Module: pe_mac_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, float word width (16 = IEEE-754 half, 32 = single; other values unsupported).
REQ-002 SHALL have parameter KERNEL_LEN, default 9, operand pairs per result (legal range 1..1024).
REQ-003 SHALL have parameter USE_BIAS, default 1, which when 1 adds the bias to each sum and when 0 skips the add.
REQ-004 SHALL have port clk, input, 1 bit: the only clock, with all state updated on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port clear, input, 1 bit: synchronous abort of the current result.
REQ-007 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): operand-pair handshake.
REQ-008 SHALL have ports floatA and floatB, input, DATA_WIDTH bits each: operand pair.
REQ-009 SHALL have port bias, input, DATA_WIDTH bits: bias word, sampled in BIAS state.
REQ-010 SHALL have port relu_en, input, 1 bit: ReLU enable, sampled in BIAS state.
REQ-011 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): result handshake.
REQ-012 SHALL have port result, output, DATA_WIDTH bits: registered finished sum.

Function
REQ-013 SHALL implement FSM states ACC, DRAIN, BIAS, OUT.
REQ-014 A pair SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-015 in_ready SHALL be 1 only in ACC with pair count < KERNEL_LEN and clear = 0.
REQ-016 Stage 1: each accepted pair SHALL produce prod_q = floatA*floatB (float multiply, DATA_WIDTH), registered with prod_v = 1; prod_v = 0 on edges with no acceptance.
REQ-017 Stage 2: on each edge where prod_v = 1, acc SHALL become acc + prod_q (float add, DATA_WIDTH).
REQ-018 A pair counter SHALL increment per accepted pair; acceptance of pair KERNEL_LEN SHALL move ACC to DRAIN.
REQ-019 DRAIN SHALL last exactly 1 cycle (last product accumulated), then move to BIAS.
REQ-020 BIAS SHALL last 1 cycle: result <= acc + bias (acc if USE_BIAS = 0); if relu_en = 1 and the sign bit of that sum = 1, result <= 0; then move to OUT.
REQ-021 out_valid SHALL be 1 exactly while in OUT, i.e. first asserted 3 cycles after the cycle the last pair is accepted.
REQ-022 In OUT, result SHALL hold stable until out_ready = 1; that edge SHALL move to ACC with acc = 0, counter = 0, prod_v = 0.
REQ-023 KERNEL_LEN = 1 SHALL be legal: 1 pair, then DRAIN, BIAS, OUT.
REQ-024 Idle cycles (in_valid = 0) in ACC SHALL not change acc or counter beyond draining a pending prod_q.
REQ-025 clear = 1 in any state SHALL on that edge force ACC, acc = 0, counter = 0, prod_v = 0, out_valid = 0; result SHALL keep its value.
REQ-026 clear SHALL have priority over in_valid, out_ready and all state transitions on the same edge; a pair presented with clear = 1 is not accepted.
REQ-027 Denormal operands and results SHALL be flushed to zero; +0 and -0 SHALL both count as zero; -0 after ReLU SHALL output 0x0.

Reset
REQ-028 reset = 1 SHALL on the edge set state = ACC, counter = 0, acc = 0, prod_q = 0, prod_v = 0, result = 0, out_valid = 0; reset has priority over clear.
REQ-029 After reset deasserts, in_ready SHALL be 1 in the first cycle; reset mid-accumulation or mid-OUT SHALL discard all partial state.

Verification (DATA_WIDTH = 16, KERNEL_LEN = 3, USE_BIAS = 1 unless noted)
REQ-030 Pairs (0x3C00,0x4000),(0x4000,0x3800),(0x4200,0x3C00) back-to-back, bias = 0x0000, relu_en = 0 -> result 0x4600 (6.0), out_valid 3 cycles after the third acceptance.
REQ-031 Same pairs, bias = 0xC800 (-8.0), relu_en = 1 -> result 0x0000; with relu_en = 0 -> 0xC000 (-2.0).
REQ-032 Same pairs with in_valid gaps of 2 idle cycles between them, and out_ready held 0 for 5 cycles in OUT -> result 0x4600 held stable, in_ready = 0 throughout OUT, then the next result accumulates from 0.
REQ-033 clear pulsed after the 2nd pair, then the 3 pairs resent -> result 0x4600 (no leakage of the partial sum); a pair driven in the clear cycle is not accepted.
REQ-034 reset asserted in OUT -> next cycle out_valid = 0, result = 0x0000, in_ready = 1; KERNEL_LEN = 1, USE_BIAS = 0, pair (0x4200,0x4000) -> result 0x4600.
